// File: rtl/store_buffer_unit_if.sv
// store_buffer_unit_if: store request, memory drain and load-hazard signals of the store buffer
interface store_buffer_unit_if;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_err;
  logic [31:0] err_addr;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic        idle;
  modport master (
    output st_valid, st_op, st_addr, st_data, dm_ack, ld_addr,
    input  st_ready, st_err, err_addr, dm_req, dm_addr, dm_be, dm_wdata, ld_hit, idle
  );
  modport slave (
    input  st_valid, st_op, st_addr, st_data, dm_ack, ld_addr,
    output st_ready, st_err, err_addr, dm_req, dm_addr, dm_be, dm_wdata, ld_hit, idle
  );
endinterface

// File: rtl/store_buffer_unit.sv
// store_buffer_unit: aligns sw/sh/sb into lane-enabled words, queues them in order and drains to memory
module store_buffer_unit #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic clk,
  input logic reset_n,
  store_buffer_unit_if.slave sb
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, REQ} state_t;
  state_t      state;
  logic [CW-1:0] count, cnt_nxt;
  logic [AW-1:0] rd, wr;
  logic [DEPTH-1:0] vld, hit;
  logic [29:0] ea [DEPTH];
  logic [3:0]  eb [DEPTH];
  logic [31:0] ed [DEPTH];
  logic [1:0]  a;
  logic        accept, legal, push, pop, err;
  logic [3:0]  be;
  logic [31:0] wd, err_addr;
  logic        unused_ld;
  assign a        = sb.st_addr[1:0];
  assign sb.st_ready = reset_n & (count != CW'(DEPTH));
  assign accept   = sb.st_valid & sb.st_ready;
  assign legal    = (sb.st_op == 2'b00) ? (a == 2'b00) : (sb.st_op == 2'b01) ? ~a[0] : (sb.st_op == 2'b10);
  assign push     = accept & legal;
  assign pop      = (state == REQ) & sb.dm_ack;
  assign cnt_nxt  = count + CW'(push) - CW'(pop);
  assign be       = (sb.st_op == 2'b00) ? 4'b1111 : (sb.st_op == 2'b01) ? 4'b0011 << {a[1], 1'b0} : 4'b0001 << a;
  assign wd       = (sb.st_op == 2'b00) ? sb.st_data :
                    (sb.st_op == 2'b01) ? {16'b0, sb.st_data[15:0]} << {a[1], 4'b0} :
                                          {24'b0, sb.st_data[7:0]} << {a, 3'b0};
  assign sb.dm_req   = (state == REQ);
  assign sb.dm_addr  = {ea[rd], 2'b00};
  assign sb.dm_be    = eb[rd];
  assign sb.dm_wdata = ed[rd];
  assign sb.idle     = (count == '0) & (state == IDLE);
  assign sb.st_err   = err;
  assign sb.err_addr = err_addr;
  assign sb.ld_hit   = |hit;
  assign unused_ld   = ^sb.ld_addr[1:0];
  // word-address match of the load against every queued entry, head included
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) hit[i] = vld[i] & (ea[i] == sb.ld_addr[31:2]);
  end
  // occupancy, pointers, drain state and the rejected-store report
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= '0;
      rd       <= '0;
      wr       <= '0;
      vld      <= '0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      count <= cnt_nxt;
      if (pop) rd <= rd + 1'b1;
      if (push) wr <= wr + 1'b1;
      if (pop) vld[rd] <= 1'b0;
      if (push) vld[wr] <= 1'b1;
      err <= accept & ~legal;
      if (accept & ~legal) err_addr <= sb.st_addr;
      state <= (state == IDLE) ? ((count != '0) ? REQ : IDLE) : ((pop & (cnt_nxt == '0)) ? IDLE : REQ);
    end
  end
  // entry payload is only meaningful while its valid bit is set, so it needs no reset
  always_ff @(posedge clk) begin
    if (push) begin
      ea[wr] <= sb.st_addr[31:2];
      eb[wr] <= be;
      ed[wr] <= wd;
    end
  end
endmodule

// File: tb/tb_store_buffer_unit.sv
// tb_store_buffer_unit: scoreboard bench with a queue-based reference of the store buffer
module tb_store_buffer_unit;
  localparam int DEPTH = 4;
  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } ent_t;
  logic clk, reset_n;
  store_buffer_unit_if bus();
  store_buffer_unit #(.DEPTH(DEPTH), .CW(3)) dut (.clk(clk), .reset_n(reset_n), .sb(bus));
  int tests = 0, fails = 0;
  ent_t pend[$];
  ent_t sb_q[$];
  bit mreq = 0, merr = 0, armed = 0;
  logic [31:0] merra = 0;
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endfunction
  function automatic bit is_legal(logic [1:0] op, logic [31:0] ad);
    int sz;
    if (op == 2'b11) return 0;
    sz = (op == 2'b00) ? 4 : (op == 2'b01) ? 2 : 1;
    return (ad % sz) == 0;
  endfunction
  function automatic ent_t enc(logic [1:0] op, logic [31:0] ad, logic [31:0] dt);
    ent_t e;
    int n, l;
    e.a = ad & ~32'h3;
    e.be = '0;
    e.d = '0;
    n = (op == 2'b00) ? 4 : (op == 2'b01) ? 2 : 1;
    for (int i = 0; i < n; i++) begin
      l = int'(ad[1:0]) + i;
      e.be[l] = 1'b1;
      e.d[8*l +: 8] = dt[8*i +: 8];
    end
    return e;
  endfunction
  function automatic bit model_hit(logic [31:0] la);
    foreach (pend[i]) if (pend[i].a[31:2] == la[31:2]) return 1;
    return 0;
  endfunction
  // reference: what the buffer holds after each edge, derived from the accept/drain rules
  always @(posedge clk) begin
    bit acc, ok, pop;
    int n;
    ent_t e;
    if (!reset_n) begin
      pend.delete();
      sb_q.delete();
      mreq = 0;
      merr = 0;
      merra = 0;
      armed = 1;
    end else begin
      n = pend.size();
      acc = bus.st_valid && (n != DEPTH);
      ok = is_legal(bus.st_op, bus.st_addr);
      pop = mreq && bus.dm_ack;
      if (pop) void'(pend.pop_front());
      if (acc && ok) begin
        e = enc(bus.st_op, bus.st_addr, bus.st_data);
        pend.push_back(e);
        sb_q.push_back(e);
      end
      mreq = mreq ? (pop ? (pend.size() != 0) : 1'b1) : (n != 0);
      merr = acc && !ok;
      if (merr) merra = bus.st_addr;
    end
  end
  // monitor: status outputs every cycle, and a scoreboard pop on every memory handshake
  always @(negedge clk) begin
    ent_t e;
    if (armed) begin
      chk("st_ready", bus.st_ready, reset_n && (pend.size() != DEPTH));
      chk("dm_req", bus.dm_req, mreq);
      chk("idle", bus.idle, (pend.size() == 0) && !mreq);
      chk("ld_hit", bus.ld_hit, model_hit(bus.ld_addr));
      chk("st_err", bus.st_err, merr);
      chk("err_addr", bus.err_addr, merra);
      if (reset_n && bus.dm_req && bus.dm_ack) begin
        if (sb_q.size() == 0) chk("unexpected_drain", bus.dm_addr, 32'hxxxxxxxx);
        else begin
          e = sb_q.pop_front();
          chk("dm_addr", bus.dm_addr, e.a);
          chk("dm_be", bus.dm_be, e.be);
          chk("dm_wdata", bus.dm_wdata, e.d);
        end
      end
    end
  end
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_store(logic [1:0] op, logic [31:0] ad, logic [31:0] dt);
    bit r, done;
    done = 0;
    bus.st_valid = 1;
    bus.st_op = op;
    bus.st_addr = ad;
    bus.st_data = dt;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      r = bus.st_ready;
      @(posedge clk);
      done = r;
    end
    #1;
    bus.st_valid = 0;
    if (!done) chk("store_timeout", 0, 1);
  endtask
  task automatic expect_drain(logic [31:0] ad, logic [3:0] be, logic [31:0] dt);
    bit got;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.dm_req && bus.dm_ack) begin
        got = 1;
        chk("drain_addr", bus.dm_addr, ad);
        chk("drain_be", bus.dm_be, be);
        chk("drain_wdata", bus.dm_wdata, dt);
      end
    end
    if (!got) chk("drain_timeout", 0, 1);
    tick();
  endtask
  initial begin
    bit seen;
    reset_n = 0;
    bus.st_valid = 0;
    bus.st_op = 0;
    bus.st_addr = 0;
    bus.st_data = 0;
    bus.dm_ack = 0;
    bus.ld_addr = 0;
    tick(2);
    chk("reset_idle", bus.idle, 1);
    chk("reset_req", bus.dm_req, 0);
    reset_n = 1;
    bus.dm_ack = 1;
    do_store(2'b00, 32'h1004, 32'hDEADBEEF);
    @(negedge clk);
    chk("sw_lat_early", bus.dm_req, 0);
    @(negedge clk);
    chk("sw_lat_req", bus.dm_req, 1);
    chk("sw_addr", bus.dm_addr, 32'h1004);
    chk("sw_be", bus.dm_be, 4'b1111);
    chk("sw_wdata", bus.dm_wdata, 32'hDEADBEEF);
    tick(2);
    chk("sw_idle_after", bus.idle, 1);
    do_store(2'b10, 32'h2003, 32'h000000A5);
    expect_drain(32'h2000, 4'b1000, 32'hA5000000);
    do_store(2'b01, 32'h2002, 32'h00001234);
    expect_drain(32'h2000, 4'b1100, 32'h12340000);
    tick(2);
    do_store(2'b00, 32'h3002, 32'h11111111);
    @(negedge clk);
    chk("mis_err", bus.st_err, 1);
    chk("mis_err_addr", bus.err_addr, 32'h3002);
    @(negedge clk);
    chk("mis_err_clear", bus.st_err, 0);
    chk("mis_no_req", bus.dm_req, 0);
    chk("mis_idle", bus.idle, 1);
    tick();
    do_store(2'b11, 32'h3000, 32'h22222222);
    @(negedge clk);
    chk("ill_err", bus.st_err, 1);
    chk("ill_err_addr", bus.err_addr, 32'h3000);
    @(negedge clk);
    chk("ill_no_req", bus.dm_req, 0);
    tick();
    bus.dm_ack = 0;
    for (int i = 0; i < 4; i++) do_store(2'b00, 32'h5000 + 32'(4*i), 32'hA0000000 + 32'(i));
    @(negedge clk);
    chk("full_ready", bus.st_ready, 0);
    tick();
    bus.st_valid = 1;
    bus.st_op = 2'b00;
    bus.st_addr = 32'h6000;
    bus.st_data = 32'h66666666;
    bus.dm_ack = 1;
    tick();
    bus.st_valid = 0;
    tick(3);
    bus.dm_ack = 0;
    tick(2);
    chk("full_drained_idle", bus.idle, 1);
    do_store(2'b10, 32'h4001, 32'h0000005A);
    bus.ld_addr = 32'h4000;
    @(negedge clk);
    chk("hit_same_word", bus.ld_hit, 1);
    tick();
    bus.ld_addr = 32'h4004;
    @(negedge clk);
    chk("hit_other_word", bus.ld_hit, 0);
    tick();
    bus.ld_addr = 32'h4000;
    bus.dm_ack = 1;
    tick(3);
    @(negedge clk);
    chk("hit_after_pop", bus.ld_hit, 0);
    tick();
    bus.dm_ack = 0;
    do_store(2'b00, 32'h8000, 32'h80808080);
    do_store(2'b00, 32'h8004, 32'h84848484);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.dm_req;
    end
    if (!seen) chk("rst_wait_req", 0, 1);
    tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    bus.dm_ack = 1;
    @(negedge clk);
    chk("rst_req", bus.dm_req, 0);
    chk("rst_idle", bus.idle, 1);
    chk("rst_ready", bus.st_ready, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_no_more_req", bus.dm_req, 0);
    end
    tick();
    for (int i = 0; i < 600; i++) begin
      bus.st_valid = $urandom_range(0, 1) == 1;
      bus.st_op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      bus.st_addr = 32'h7000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
      bus.st_data = $urandom;
      bus.dm_ack = $urandom_range(0, 2) != 0;
      bus.ld_addr = 32'h7000 + 32'($urandom_range(0, 9) << 2) + 32'($urandom_range(0, 3));
      reset_n = $urandom_range(0, 149) != 0;
      tick();
    end
    reset_n = 1;
    bus.st_valid = 0;
    bus.dm_ack = 1;
    tick(20);
    chk("final_sb_empty", sb_q.size(), 0);
    chk("final_idle", bus.idle, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/store_buffer_unit.md
Name: store_buffer_unit

Overview:
- Memory-stage store path. Takes sw/sh/sb requests from the M stage and aligns each to the 32-bit data-memory word with byte enables.
- Queues requests in a small in-order write buffer and drains them to data memory over a req/ack handshake.
- Complements the W-stage load extraction: loads pick lanes out of a word, and this block places lanes into one.
- Exposes a word-address hit check so the hazard unit stalls loads that overlap pending stores.

Parameters:
- DEPTH, 4, write-buffer entries (power of two, 2..16)
- CW, 3, count width; must hold 0..DEPTH

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  synchronous active-low reset
- st_valid  input  1  store request present
- st_ready  output  1  buffer can accept
- st_op  input  2  00 sw, 01 sh, 10 sb, 11 illegal
- st_addr  input  32  byte address
- st_data  input  32  rt register value
- st_err  output  1  one-cycle misaligned/illegal pulse
- err_addr  output  32  address of the last rejected store
- dm_req  output  1  memory write request
- dm_addr  output  32  word address, bits [1:0] = 0
- dm_be  output  4  byte enables, bit i means lane i ([8i+7:8i])
- dm_wdata  output  32  lane-aligned write data
- dm_ack  input  1  memory accepted current request
- ld_addr  input  32  address of the load in the M stage
- ld_hit  output  1  pending entry has the same word address
- idle  output  1  buffer empty and no request outstanding

Behaviour:
- Reset: a clock edge with reset_n=0 sets count=0, rd/wr pointers=0, state=IDLE, st_err=0, err_addr=0. All queued stores are discarded.
  - After that edge: dm_req=0, idle=1, ld_hit=0.
  - st_ready is forced 0 while reset_n=0.
  - A request abandoned by reset mid-handshake is not retried; memory ignores dm_ack after dm_req drops.
- Accept: a store is taken on an edge where st_valid & st_ready. st_ready = (count != DEPTH), from registered count.
  - A pop in the same cycle does not free a slot for a push while full.
- Alignment check, a=st_addr[1:0]:
  - sw needs a=00; sh needs a[0]=0; op 11 is always illegal.
  - A failing store is still handshaken (consumes st_valid) but is not enqueued.
  - Next cycle: st_err=1 for one cycle; err_addr=st_addr.
- Lane encoding, stored in the entry at accept:
  - sw: be=1111, wdata=st_data.
  - sh: be=0011<<(2*a[1]), wdata=st_data[15:0]<<(16*a[1]).
  - sb: be=0001<<a, wdata=st_data[7:0]<<(8*a).
  - Unused lanes are zero. addr stored as {st_addr[31:2],2'b00}.
- Drain FSM:
  - IDLE -> REQ when count!=0 at the edge.
  - dm_req=(state==REQ). dm_addr/dm_be/dm_wdata show the head entry and stay stable until dm_ack.
  - In REQ, dm_ack=1 pops the head. Stay in REQ if (count-1+push)!=0, else go to IDLE. Back-to-back requests need no gap.
  - dm_ack while in IDLE is ignored.
  - Minimum latency: store accepted at edge N, dm_req high in cycle after edge N+1.
- Simultaneous push and pop: count unchanged, pointers both advance, wrap modulo DEPTH.
- ld_hit: combinational. OR over valid entries of (entry.addr[31:2]==ld_addr[31:2]). Includes the head currently being requested.
  - A store accepted this cycle is not visible until the next cycle; the hazard unit covers the M-stage store itself.
- idle = (count==0) & (state==IDLE). Used for syscall/eret/program-end sync.
- Ordering is strict FIFO; no write merging or coalescing.

Test Plan:
- Reset, then sw addr 0x0000_1004 data 0xDEADBEEF, dm_ack tied 1 -> dm_req high 2 cycles after accept; dm_addr=0x1004, be=1111, wdata=0xDEADBEEF; idle=1 afterward.
- sb addr 0x2003 data 0x000000A5 -> be=1000, wdata=0xA5000000. sh addr 0x2002 data 0x1234 -> be=1100, wdata=0x12340000.
- sw addr 0x3002 -> st_err pulses one cycle, err_addr=0x3002, no dm_req, count stays 0. Same result for op=11 at addr 0x3000.
- dm_ack held 0, push 4 sw -> st_ready=0 after the 4th. Push and ack in the same cycle while full -> 5th store not taken.
  - Release ack for 4 consecutive cycles -> entries drain in order, back-to-back, pointers wrap cleanly.
- Pending sb to 0x4001, ld_addr=0x4000 -> ld_hit=1; ld_addr=0x4004 -> ld_hit=0. After the pop is acked, ld_hit=0 for 0x4000.
- Two queued stores with dm_req high, reset_n low for one edge -> dm_req=0, idle=1, st_ready=1 next cycle; no further requests issued.
